// File: rtl/tinyml_router_pkg.sv
// Shared types and helpers for the tinyML command router.
package tinyml_router_pkg;

    localparam int FID_W = 10;
    localparam logic [31:0] ERR_CODE_DEFAULT = 32'hDEAD_0001;

    // Order-FIFO tag. The id field is sized for the widest possible selector;
    // only the low UNIT_SEL_W bits are ever non-zero.
    typedef struct packed {
        logic             err;
        logic [FID_W-1:0] id;
    } tag_t;

    // Unit selector: the top sel_w bits of the function ID, right-aligned.
    function automatic logic [FID_W-1:0] get_sel(input logic [FID_W-1:0] fid,
                                                 input int unsigned      sel_w);
        return fid >> (FID_W - sel_w);
    endfunction

endpackage

// File: rtl/tinyml_order_fifo.sv
// Tag FIFO remembering the issue order of outstanding commands.
module tinyml_order_fifo
    import tinyml_router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  tag_t                     push_tag,
    input  logic                     pop,
    output tag_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tag_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state pointers and occupancy; pointers wrap because DEPTH is a power of 2.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; an entry is only read after count shows it was written.
        if (push) mem_q[wr_ptr_q] <= push_tag;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/tinyml_cmd_router.sv
// Routes CPU custom-instruction commands to NUM_UNITS units and returns
// responses strictly in issue order; unmapped selectors get a local error reply.
module tinyml_cmd_router
    import tinyml_router_pkg::*;
#(
    parameter int                   NUM_UNITS   = 2,
    parameter int                   UNIT_SEL_W  = 1,
    parameter int                   ORDER_DEPTH = 4,
    parameter logic [31:0]          ERR_CODE    = ERR_CODE_DEFAULT,
    parameter logic [NUM_UNITS-1:0] INT_MASK    = {NUM_UNITS{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    input  logic [9:0]              cmd_function_id,
    input  logic [31:0]             cmd_inputs_0,
    input  logic [31:0]             cmd_inputs_1,
    output logic                    cmd_ready,
    output logic                    cmd_int,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_outputs_0,
    input  logic                    rsp_ready,
    output logic [NUM_UNITS-1:0]    u_cmd_valid,
    output logic [9:0]              u_cmd_function_id,
    output logic [31:0]             u_cmd_inputs_0,
    output logic [31:0]             u_cmd_inputs_1,
    input  logic [NUM_UNITS-1:0]    u_cmd_ready,
    input  logic [NUM_UNITS-1:0]    u_rsp_valid,
    input  logic [32*NUM_UNITS-1:0] u_rsp_outputs_0,
    output logic [NUM_UNITS-1:0]    u_rsp_ready,
    input  logic [NUM_UNITS-1:0]    u_int,
    output logic [15:0]             err_count
);

    localparam int CNT_W = $clog2(ORDER_DEPTH) + 1;

    logic [FID_W-1:0] sel;
    logic             mapped;
    logic             not_full;
    logic             unit_ready;
    logic             push, pop;
    tag_t             push_tag, head;
    logic [CNT_W-1:0] count;
    logic [15:0]      err_count_q, err_count_d;
    logic             cmd_int_q;

    assign sel      = get_sel(cmd_function_id, UNIT_SEL_W);
    assign mapped   = ({22'd0, sel} < 32'(NUM_UNITS));
    // Depends only on the registered count, so a push can never hit a full FIFO.
    assign not_full = (count < CNT_W'(ORDER_DEPTH));

    // Command steering: only the selected unit sees valid; its ready gates the CPU.
    always_comb begin
        u_cmd_valid = '0;
        unit_ready  = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel == FID_W'(k)) begin
                u_cmd_valid[k] = cmd_valid & not_full;
                unit_ready     = u_cmd_ready[k];
            end
        end
    end

    assign cmd_ready         = not_full & (mapped ? unit_ready : 1'b1);
    assign u_cmd_function_id = cmd_function_id;
    assign u_cmd_inputs_0    = cmd_inputs_0;
    assign u_cmd_inputs_1    = cmd_inputs_1;
    assign push              = cmd_valid & cmd_ready;

    // Tag recorded on accept: error flag for unmapped selectors, else the unit index.
    always_comb begin
        push_tag     = '0;
        push_tag.err = ~mapped;
        push_tag.id  = mapped ? sel : '0;
    end

    tinyml_order_fifo #(
        .DEPTH    (ORDER_DEPTH)
    ) u_order_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    // Response steering from the head tag; non-head units see ready low and hold.
    always_comb begin
        rsp_valid     = 1'b0;
        rsp_outputs_0 = '0;
        u_rsp_ready   = '0;
        if (count != '0) begin
            if (head.err) begin
                rsp_valid     = 1'b1;
                rsp_outputs_0 = ERR_CODE;
            end else begin
                for (int k = 0; k < NUM_UNITS; k++) begin
                    if (head.id == FID_W'(k)) begin
                        rsp_valid      = u_rsp_valid[k];
                        rsp_outputs_0  = u_rsp_outputs_0[32*k +: 32];
                        u_rsp_ready[k] = rsp_ready;
                    end
                end
            end
        end
    end

    assign pop = rsp_valid & rsp_ready;

    // Saturating count of accepted unmapped commands.
    always_comb begin
        err_count_d = err_count_q;
        if (push && !mapped && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end

    // Error counter and merged, masked, level-sensitive interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count_q <= '0;
            cmd_int_q   <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            cmd_int_q   <= |(u_int & INT_MASK);
        end
    end

    assign err_count = err_count_q;
    assign cmd_int   = cmd_int_q;

endmodule

// File: tb/tb_tinyml_cmd_router.sv
// Self-checking bench: scoreboard of expected CPU responses plus a simple
// unit model that answers one cycle after accept unless held.
module tb_tinyml_cmd_router;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // DUT A: defaults
    logic        a_cmd_valid;
    logic [9:0]  a_fid;
    logic [31:0] a_in0, a_in1;
    logic        a_cmd_ready, a_cmd_int, a_rsp_valid, a_rsp_ready;
    logic [31:0] a_rsp_data;
    logic [1:0]  a_u_cmd_valid, a_u_cmd_ready, a_u_rsp_valid, a_u_rsp_ready, a_u_int;
    logic [9:0]  a_u_fid;
    logic [31:0] a_u_in0, a_u_in1;
    logic [63:0] a_u_rsp_data;
    logic [15:0] a_err_count;

    // DUT C: same inputs as A, INT_MASK = 2'b01
    logic        c_cmd_ready, c_cmd_int, c_rsp_valid;
    logic [31:0] c_rsp_data, c_u_in0, c_u_in1;
    logic [1:0]  c_u_cmd_valid, c_u_rsp_ready;
    logic [9:0]  c_u_fid;
    logic [15:0] c_err_count;

    // DUT B: UNIT_SEL_W=2, NUM_UNITS=3
    logic        b_cmd_valid, b_cmd_ready, b_cmd_int, b_rsp_valid, b_rsp_ready;
    logic [9:0]  b_fid, b_u_fid;
    logic [31:0] b_rsp_data, b_u_in0, b_u_in1;
    logic [2:0]  b_u_cmd_valid, b_u_cmd_ready, b_u_rsp_valid, b_u_rsp_ready, b_u_int;
    logic [95:0] b_u_rsp_data;
    logic [15:0] b_err_count;

    tinyml_cmd_router u_dut_a (
        .clk(clk), .rstn(rstn), .cmd_valid(a_cmd_valid), .cmd_function_id(a_fid),
        .cmd_inputs_0(a_in0), .cmd_inputs_1(a_in1), .cmd_ready(a_cmd_ready),
        .cmd_int(a_cmd_int), .rsp_valid(a_rsp_valid), .rsp_outputs_0(a_rsp_data),
        .rsp_ready(a_rsp_ready), .u_cmd_valid(a_u_cmd_valid), .u_cmd_function_id(a_u_fid),
        .u_cmd_inputs_0(a_u_in0), .u_cmd_inputs_1(a_u_in1), .u_cmd_ready(a_u_cmd_ready),
        .u_rsp_valid(a_u_rsp_valid), .u_rsp_outputs_0(a_u_rsp_data),
        .u_rsp_ready(a_u_rsp_ready), .u_int(a_u_int), .err_count(a_err_count)
    );

    tinyml_cmd_router #(.INT_MASK(2'b01)) u_dut_c (
        .clk(clk), .rstn(rstn), .cmd_valid(a_cmd_valid), .cmd_function_id(a_fid),
        .cmd_inputs_0(a_in0), .cmd_inputs_1(a_in1), .cmd_ready(c_cmd_ready),
        .cmd_int(c_cmd_int), .rsp_valid(c_rsp_valid), .rsp_outputs_0(c_rsp_data),
        .rsp_ready(a_rsp_ready), .u_cmd_valid(c_u_cmd_valid), .u_cmd_function_id(c_u_fid),
        .u_cmd_inputs_0(c_u_in0), .u_cmd_inputs_1(c_u_in1), .u_cmd_ready(a_u_cmd_ready),
        .u_rsp_valid(a_u_rsp_valid), .u_rsp_outputs_0(a_u_rsp_data),
        .u_rsp_ready(c_u_rsp_ready), .u_int(a_u_int), .err_count(c_err_count)
    );

    tinyml_cmd_router #(.NUM_UNITS(3), .UNIT_SEL_W(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .cmd_valid(b_cmd_valid), .cmd_function_id(b_fid),
        .cmd_inputs_0(a_in0), .cmd_inputs_1(a_in1), .cmd_ready(b_cmd_ready),
        .cmd_int(b_cmd_int), .rsp_valid(b_rsp_valid), .rsp_outputs_0(b_rsp_data),
        .rsp_ready(b_rsp_ready), .u_cmd_valid(b_u_cmd_valid), .u_cmd_function_id(b_u_fid),
        .u_cmd_inputs_0(b_u_in0), .u_cmd_inputs_1(b_u_in1), .u_cmd_ready(b_u_cmd_ready),
        .u_rsp_valid(b_u_rsp_valid), .u_rsp_outputs_0(b_u_rsp_data),
        .u_rsp_ready(b_u_rsp_ready), .u_int(b_u_int), .err_count(b_err_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb_q[$];   // expected CPU responses of DUT A, in issue order
    logic [31:0] uq0[$];    // unit 0 pending responses
    logic [31:0] uq1[$];    // unit 1 pending responses
    logic [1:0]  hold;      // unit k withholds its response while hold[k]
    logic        a_acc;

    task automatic check(input string tag, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act_v, exp_v);
        end
    endtask

    // Expected CPU-side data: unit sel answers in0 + in1 + sel.
    function automatic logic [31:0] exp_data(input logic [9:0] fid, input logic [31:0] x, input logic [31:0] y);
        return x + y + {31'd0, fid[9]};
    endfunction

    task automatic drive_units();
        a_u_rsp_valid[0]     = (uq0.size() != 0) && !hold[0];
        a_u_rsp_valid[1]     = (uq1.size() != 0) && !hold[1];
        a_u_rsp_data[31:0]   = (uq0.size() != 0) ? uq0[0] : 32'h0;
        a_u_rsp_data[63:32]  = (uq1.size() != 0) ? uq1[0] : 32'h0;
    endtask

    // One clock: observe handshakes at the negedge, update the unit model after the posedge.
    task automatic step();
        @(negedge clk);
        a_acc = a_cmd_valid && a_cmd_ready;
        if (rstn) begin
            if (a_acc) sb_q.push_back(exp_data(a_fid, a_in0, a_in1));
            if (a_u_cmd_valid[0] && a_u_cmd_ready[0]) uq0.push_back(a_u_in0 + a_u_in1);
            if (a_u_cmd_valid[1] && a_u_cmd_ready[1]) uq1.push_back(a_u_in0 + a_u_in1 + 32'd1);
            if (a_rsp_valid && a_rsp_ready) begin
                if (sb_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else check("rsp_data", a_rsp_data, sb_q.pop_front());
            end
            if (a_u_rsp_valid[0] && a_u_rsp_ready[0]) void'(uq0.pop_front());
            if (a_u_rsp_valid[1] && a_u_rsp_ready[1]) void'(uq1.pop_front());
        end
        @(posedge clk);
        #1;
        drive_units();
    endtask

    task automatic send(input logic [9:0] fid, input logic [31:0] x, input logic [31:0] y);
        a_cmd_valid = 1'b1;
        a_fid = fid;
        a_in0 = x;
        a_in1 = y;
        a_acc = 1'b0;
        for (int i = 0; i < 20 && !a_acc; i++) step();
        check("send_accepted", a_acc, 1'b1);
        a_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        a_cmd_valid = 1'b0;
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) step();
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        rstn = 1'b0;
        a_cmd_valid = 1'b0; a_fid = '0; a_in0 = '0; a_in1 = '0; a_rsp_ready = 1'b0;
        a_u_cmd_ready = 2'b11; a_u_rsp_valid = '0; a_u_rsp_data = '0; a_u_int = '0;
        b_cmd_valid = 1'b0; b_fid = '0; b_rsp_ready = 1'b0;
        b_u_cmd_ready = 3'b111; b_u_rsp_valid = '0; b_u_rsp_data = '0; b_u_int = '0;
        hold = 2'b00;

        // Reset state
        #12;
        check("rst_rsp_valid", a_rsp_valid, 1'b0);
        check("rst_cmd_int", a_cmd_int, 1'b0);
        check("rst_err_count", b_err_count, 16'd0);
        check("rst_u_rsp_ready", a_u_rsp_ready, 2'b00);
        check("rst_cmd_ready", a_cmd_ready, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        drive_units();

        // 1: out-of-order unit completion is held back until unit 0 answers
        hold = 2'b01;
        a_rsp_ready = 1'b1;
        a_cmd_valid = 1'b1; a_fid = 10'h005; #1;
        check("t1_u_cmd_valid0", a_u_cmd_valid, 2'b01);
        send(10'h005, 32'd1, 32'd2);
        a_cmd_valid = 1'b1; a_fid = 10'h205; #1;
        check("t1_u_cmd_valid1", a_u_cmd_valid, 2'b10);
        send(10'h205, 32'd10, 32'd20);
        step();
        step();
        check("t1_held_rsp_valid", a_rsp_valid, 1'b0);
        check("t1_held_u_rsp_ready", a_u_rsp_ready, 2'b01);
        hold = 2'b00;
        drive_units();
        drain();

        // 2: unmapped selector answered locally
        b_rsp_ready = 1'b0;
        b_cmd_valid = 1'b1; b_fid = 10'h280; #1;
        check("t2_mapped_valid", b_u_cmd_valid, 3'b100);
        b_fid = 10'h3C0; #1;
        check("t2_err_cmd_ready", b_cmd_ready, 1'b1);
        check("t2_err_u_cmd_valid", b_u_cmd_valid, 3'b000);
        check("t2_err_rsp_before", b_rsp_valid, 1'b0);
        step();
        b_cmd_valid = 1'b0; #1;
        check("t2_err_rsp_valid", b_rsp_valid, 1'b1);
        check("t2_err_rsp_data", b_rsp_data, 32'hDEAD_0001);
        check("t2_err_count", b_err_count, 16'd1);
        b_rsp_ready = 1'b1;
        step();
        check("t2_err_popped", b_rsp_valid, 1'b0);

        // 3: order FIFO fills, fifth command held until one pop
        a_rsp_ready = 1'b0;
        send(10'h010, 32'd1, 32'h100);
        send(10'h210, 32'd2, 32'h100);
        send(10'h011, 32'd3, 32'h100);
        send(10'h211, 32'd4, 32'h100);
        a_cmd_valid = 1'b1; a_fid = 10'h012; a_in0 = 32'd5; a_in1 = 32'h100; #1;
        check("t3_full_cmd_ready", a_cmd_ready, 1'b0);
        check("t3_full_u_cmd_valid", a_u_cmd_valid, 2'b00);
        step();
        step();
        check("t3_still_full", a_cmd_ready, 1'b0);
        check("t3_head_valid", a_rsp_valid, 1'b1);
        a_rsp_ready = 1'b1;
        step();
        check("t3_ready_after_pop", a_cmd_ready, 1'b1);
        a_acc = 1'b0;
        step();
        check("t3_fifth_accepted", a_acc, 1'b1);
        drain();

        // 4: push and pop every cycle, pointers wrap
        send(10'h000, 32'd77, 32'd0);
        a_rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [9:0] f;
            f = 10'(i);
            f[9] = f[0];
            a_cmd_valid = 1'b1; a_fid = f; a_in0 = 32'(i * 7); a_in1 = 32'(100 + i);
            #1;
            check("t4_cmd_ready", a_cmd_ready, 1'b1);
            check("t4_rsp_valid", a_rsp_valid, 1'b1);
            step();
        end
        drain();

        // 5: masked interrupt merge, one-cycle latency, level based
        a_u_int = 2'b10;
        step();
        check("t5_masked_c", c_cmd_int, 1'b0);
        check("t5_unmasked_a", a_cmd_int, 1'b1);
        a_u_int = 2'b01; #1;
        check("t5_not_yet", c_cmd_int, 1'b0);
        step();
        check("t5_c_raised", c_cmd_int, 1'b1);
        a_u_int = 2'b00;
        step();
        check("t5_c_level", c_cmd_int, 1'b0);
        check("t5_a_level", a_cmd_int, 1'b0);

        // 6: reset with outstanding commands, then normal operation
        a_rsp_ready = 1'b0;
        send(10'h001, 32'd9, 32'd9);
        send(10'h201, 32'd8, 32'd8);
        send(10'h002, 32'd7, 32'd7);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_rsp_valid", a_rsp_valid, 1'b0);
        check("t6_rst_err_count", b_err_count, 16'd0);
        check("t6_rst_u_rsp_ready", a_u_rsp_ready, 2'b00);
        check("t6_rst_cmd_ready", a_cmd_ready, 1'b1);
        sb_q.delete();
        uq0.delete();
        uq1.delete();
        drive_units();
        a_rsp_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send(10'h203, 32'd5, 32'd6);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
